dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares one single-port data memory between the core load/store port and an external
//  requester (program loader / debug port). Core has priority, with a starvation cap for the
//  external side. Each access holds the memory for MEM_LATENCY cycles; the core is stalled
//  while it waits. With MEM_LATENCY=1 and no contention it is a zero-latency pass-through,
//  so the single-cycle core connects unchanged.
// PARAMETERS
//  MEM_LATENCY   1   cycles one access occupies memory (>=1); read data valid in last cycle
//  STARVE_LIMIT  4   max consecutive core grants while ext_req pending before ext forced (>=1)
// PORTS
//  clock            in   1   single clock, rising edge
//  reset            in   1   asynchronous, active-high
//  core_read        in   1   core load request (dmem_read)
//  core_write       in   1   core store request (dmem_write)
//  core_addr        in   32  core byte address
//  core_write_data  in   32  core store data
//  core_read_data   out  32  load data = mem_read_data (combinational pass-through)
//  core_stall       out  1   core access not completing this cycle; core holds inputs stable
//  ext_req          in   1   external request; level, held until ext_gnt
//  ext_we           in   1   1=write, 0=read; sampled with ext_gnt
//  ext_addr         in   32  sampled with ext_gnt
//  ext_wdata        in   32  sampled with ext_gnt
//  ext_gnt          out  1   1-cycle pulse: ext access starts this cycle
//  ext_rdata        out  32  registered read data, held until next ext read completes
//  ext_rvalid       out  1   1-cycle pulse, cycle after ext read completes
//  mem_read         out  1   to memory
//  mem_write        out  1   to memory
//  mem_addr         out  32  to memory
//  mem_write_data   out  32  to memory
//  mem_read_data    in   32  from memory, valid in last cycle of an access
// BEHAVIOUR
//  - States: IDLE, BUSY (owner CORE|EXT, down-counter cnt). Reset -> IDLE, cnt=0, starve=0,
//    ext_rdata=0, ext_rvalid=0. While reset high: mem_read/mem_write/ext_gnt/core_stall = 0.
//  - Arbitration, only in IDLE, combinational in that cycle:
//      ext_req && starve==STARVE_LIMIT -> EXT; else core_read|core_write -> CORE;
//      else ext_req -> EXT; else no access (mem_read=mem_write=0).
//  - Access granted at cycle t occupies t..t+MEM_LATENCY-1; completes at the last cycle.
//    MEM_LATENCY=1: stays IDLE. Else -> BUSY, cnt=MEM_LATENCY-1, decrement each cycle,
//    cnt==1 is the final cycle, then IDLE. Next arbitration at t+MEM_LATENCY: no bubble.
//  - mem_* mux: CORE owner -> live core_* inputs; EXT owner -> copies latched at ext_gnt.
//  - core_write && core_read together: treated as write, mem_read=0.
//  - core_stall = (core_read|core_write) && !(core owns memory && final cycle).
//  - ext write: no ext_rvalid. ext read: ext_rdata <= mem_read_data at final cycle,
//    ext_rvalid pulses next cycle.
//  - starve counter: +1 (saturating at STARVE_LIMIT) per core grant while ext_req=1;
//    cleared on ext grant or when ext_req=0.
//  - ext_req dropped before ext_gnt: request withdrawn, no access. ext_req still high after
//    ext_gnt: counts as a new request.
//  - Reset mid-access: in-flight access abandoned, no ext_rvalid, back to IDLE.
// STRUCTURE
//  - Shared header dmem_arb_defs.vh: state codes (ST_IDLE, ST_BUSY), owner codes
//    (OWN_CORE, OWN_EXT), default MEM_LATENCY/STARVE_LIMIT.
//  - One sub-module access_timer: loadable down-counter, outputs busy and last.
//    Arbiter FSM, starve counter, ext latches and output muxes stay in dmem_arbiter.
// TESTING
//  1 LAT=1, core_read addr 0x10, mem returns 0xCAFEF00D -> same cycle core_read_data=0xCAFEF00D,
//    core_stall=0, mem_read=1, mem_addr=0x10
//  2 LAT=3, core_write 0x20 <- 0x1234 from IDLE -> core_stall=1,1,0; mem_write high 3 cycles;
//    IDLE on cycle 4
//  3 LAT=2, ext read 0x40 idle, mem returns 0xA5A5A5A5 -> ext_gnt at t; ext_rdata=0xA5A5A5A5,
//    ext_rvalid pulse at t+2
//  4 LAT=1, STARVE_LIMIT=4, core_read and ext_req held high -> 4 core grants, ext granted on 5th,
//    core_stall=1 that cycle only
//  5 LAT=2, core_read and core_write both high -> mem_write=1, mem_read=0
//  6 LAT=3, reset pulsed in 2nd cycle of ext read -> no ext_rvalid, outputs 0;
//    next ext read completes normally

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_arbiter_pkg;

  typedef enum logic {StIdle, StBusy} state_e;
  typedef enum logic {OwnCore, OwnExt} owner_e;

  localparam int unsigned DefMemLatency  = 1;
  localparam int unsigned DefStarveLimit = 4;

  // Bits needed to hold values 0..n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/access_timer.sv
// Loadable down-counter timing one multi-cycle memory access.
module access_timer #(
  parameter int unsigned Width = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] load_value,
  output logic             busy,
  output logic             last
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_value;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign busy = (cnt_q != '0);
  assign last = (cnt_q == Width'(1));

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between the core load/store port and an external
// requester; core has priority, bounded by a starvation cap for the external side.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_LATENCY  = DefMemLatency,
  parameter int unsigned STARVE_LIMIT = DefStarveLimit
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        core_read,
  input  logic        core_write,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_write_data,
  output logic [31:0] core_read_data,
  output logic        core_stall,
  input  logic        ext_req,
  input  logic        ext_we,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wdata,
  output logic        ext_gnt,
  output logic [31:0] ext_rdata,
  output logic        ext_rvalid,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam int unsigned CntW    = cnt_width(MEM_LATENCY);
  localparam int unsigned StarveW = cnt_width(STARVE_LIMIT);
  localparam logic [CntW-1:0]    LoadValue   = CntW'(MEM_LATENCY - 1);
  localparam logic [StarveW-1:0] StarveMax   = StarveW'(STARVE_LIMIT);
  localparam bit                 SingleCycle = (MEM_LATENCY == 1);

  state_e               state_q;
  owner_e               owner_q;
  logic [StarveW-1:0]   starve_q;
  logic                 ext_we_q;
  logic [31:0]          ext_addr_q;
  logic [31:0]          ext_wdata_q;
  logic [31:0]          ext_rdata_q;
  logic                 ext_rvalid_q;

  logic                 timer_busy;
  logic                 timer_last;

  logic                 core_req;
  logic                 idle;
  logic                 grant_ext;
  logic                 grant_core;
  logic                 active;
  logic                 final_cycle;
  logic                 ext_read_done;
  owner_e               owner;
  logic                 sel_we;
  logic [31:0]          sel_addr;
  logic [31:0]          sel_wdata;

  access_timer #(
    .Width (CntW)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       ((grant_ext | grant_core) && !SingleCycle),
    .load_value (LoadValue),
    .busy       (timer_busy),
    .last       (timer_last)
  );

  always_comb begin
    core_req    = core_read | core_write;
    idle        = (state_q == StIdle);
    // Starvation cap overrides core priority; otherwise ext only gets a free slot.
    grant_ext   = !reset && idle && ext_req && (starve_q == StarveMax || !core_req);
    grant_core  = !reset && idle && core_req && !grant_ext;
    active      = !reset && (grant_ext || grant_core || timer_busy);
    owner       = idle ? (grant_ext ? OwnExt : OwnCore) : owner_q;
    final_cycle = idle ? SingleCycle : timer_last;

    // The grant cycle uses the live ext inputs; later cycles use the latched copies.
    sel_we    = idle ? ext_we    : ext_we_q;
    sel_addr  = idle ? ext_addr  : ext_addr_q;
    sel_wdata = idle ? ext_wdata : ext_wdata_q;

    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    if (active) begin
      if (owner == OwnCore) begin
        mem_write      = core_write;
        mem_read       = core_read & ~core_write;
        mem_addr       = core_addr;
        mem_write_data = core_write_data;
      end else begin
        mem_write      = sel_we;
        mem_read       = ~sel_we;
        mem_addr       = sel_addr;
        mem_write_data = sel_wdata;
      end
    end

    core_stall    = !reset && core_req && !(active && owner == OwnCore && final_cycle);
    ext_read_done = active && owner == OwnExt && final_cycle && !sel_we;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      owner_q      <= OwnCore;
      starve_q     <= '0;
      ext_we_q     <= 1'b0;
      ext_addr_q   <= '0;
      ext_wdata_q  <= '0;
      ext_rdata_q  <= '0;
      ext_rvalid_q <= 1'b0;
    end else begin
      ext_rvalid_q <= ext_read_done;
      if (ext_read_done) begin
        ext_rdata_q <= mem_read_data;
      end
      if (grant_ext) begin
        ext_we_q    <= ext_we;
        ext_addr_q  <= ext_addr;
        ext_wdata_q <= ext_wdata;
      end
      if (grant_ext || grant_core) begin
        owner_q <= grant_ext ? OwnExt : OwnCore;
      end

      unique case (state_q)
        StIdle: if ((grant_ext || grant_core) && !SingleCycle) state_q <= StBusy;
        StBusy: if (timer_last) state_q <= StIdle;
      endcase

      if (grant_ext || !ext_req) begin
        starve_q <= '0;
      end else if (grant_core && starve_q != StarveMax) begin
        starve_q <= starve_q + StarveW'(1);
      end
    end
  end

  assign core_read_data = mem_read_data;
  assign ext_gnt        = grant_ext;
  assign ext_rdata      = ext_rdata_q;
  assign ext_rvalid     = ext_rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Three arbiters (latency 1/2/3) driven by random traffic and checked against an
// access-schedule model through a shared scoreboard.
module tb_dmem_arbiter;

  localparam int NInst = 3;

  typedef struct {
    int          g;
    int          cyc;
    int          kind;   // 0 mem command, 1 core done, 2 ext grant, 3 ext rvalid
    logic        re;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        core_read       [NInst];
  logic        core_write      [NInst];
  logic [31:0] core_addr       [NInst];
  logic [31:0] core_write_data [NInst];
  logic [31:0] core_read_data  [NInst];
  logic        core_stall      [NInst];
  logic        ext_req         [NInst];
  logic        ext_we          [NInst];
  logic [31:0] ext_addr        [NInst];
  logic [31:0] ext_wdata       [NInst];
  logic        ext_gnt         [NInst];
  logic [31:0] ext_rdata       [NInst];
  logic        ext_rvalid      [NInst];
  logic        mem_read        [NInst];
  logic        mem_write       [NInst];
  logic [31:0] mem_addr        [NInst];
  logic [31:0] mem_write_data  [NInst];
  logic [31:0] mem_read_data   [NInst];

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  ev_t  sb[$];

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hCAFE_F00D;
  endfunction

  for (genvar gi = 0; gi < NInst; gi++) begin : g_dut
    dmem_arbiter #(
      .MEM_LATENCY  (gi + 1),
      .STARVE_LIMIT ((gi == 2) ? 2 : 4)
    ) u_dut (
      .clock           (clock),
      .reset           (reset),
      .core_read       (core_read[gi]),
      .core_write      (core_write[gi]),
      .core_addr       (core_addr[gi]),
      .core_write_data (core_write_data[gi]),
      .core_read_data  (core_read_data[gi]),
      .core_stall      (core_stall[gi]),
      .ext_req         (ext_req[gi]),
      .ext_we          (ext_we[gi]),
      .ext_addr        (ext_addr[gi]),
      .ext_wdata       (ext_wdata[gi]),
      .ext_gnt         (ext_gnt[gi]),
      .ext_rdata       (ext_rdata[gi]),
      .ext_rvalid      (ext_rvalid[gi]),
      .mem_read        (mem_read[gi]),
      .mem_write       (mem_write[gi]),
      .mem_addr        (mem_addr[gi]),
      .mem_write_data  (mem_write_data[gi]),
      .mem_read_data   (mem_read_data[gi])
    );
    assign mem_read_data[gi] = mem_fn(mem_addr[gi]);
  end

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int g, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s[%0d] cyc=%0d got=%h want=%h", name, g, cyc, got, want);
    end
  endtask

  task automatic push_ev(input int g, input int c, input int kind, input logic re,
                         input logic we, input logic [31:0] addr, input logic [31:0] data);
    ev_t e;
    e.g = g; e.cyc = c; e.kind = kind; e.re = re; e.we = we; e.addr = addr; e.data = data;
    sb.push_back(e);
  endtask

  // Reference: memory is free again LAT cycles after each grant; arbitration only
  // happens on a free cycle, following the priority and starvation rules.
  task automatic drive(input int g, input int ncyc, input int heavy_cycles);
    int          lat = g + 1;
    int          limit = (g == 2) ? 2 : 4;
    int          free_at = 0;
    int          starve = 0;
    int          c;
    int          core_kind = 0;
    int          core_done_at = 0;
    int          ext_gnt_at = -10;
    bit          core_pend = 0;
    bit          core_granted = 0;
    bit          ext_pend = 0;
    bit          withdrew;
    bit          heavy;
    bit          we;
    logic        ewe = 1'b0;
    logic [31:0] ca = '0, cd = '0, ea = '0, ed = '0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clock);
      #1;
      c = cyc;
      if (i == 0) free_at = c;
      heavy = (i < heavy_cycles);
      withdrew = 0;
      if (core_pend && core_granted && c > core_done_at) begin
        core_pend = 0;
        core_granted = 0;
      end
      if (!core_pend && i < ncyc && $urandom_range(99) < (heavy ? 100 : 55)) begin
        core_pend = 1;
        core_kind = $urandom_range(2);
        ca = $urandom;
        cd = $urandom;
      end
      if (ext_pend && ext_gnt_at == c - 1) begin
        ext_pend = 0;
      end else if (ext_pend && !heavy && $urandom_range(99) < 4) begin
        ext_pend = 0;
        withdrew = 1;
      end
      if (!ext_pend) begin
        ewe = 1'($urandom_range(1));
        ea = $urandom;
        ed = $urandom;
        if (!withdrew && i < ncyc && $urandom_range(99) < (heavy ? 90 : 30)) ext_pend = 1;
      end
      core_read[g]       = core_pend && core_kind != 1;
      core_write[g]      = core_pend && core_kind != 0;
      core_addr[g]       = ca;
      core_write_data[g] = cd;
      ext_req[g]         = ext_pend;
      ext_we[g]          = ewe;
      ext_addr[g]        = ea;
      ext_wdata[g]       = ed;

      if (c >= free_at) begin
        if (ext_pend && (starve >= limit || !core_pend)) begin
          for (int k = 0; k < lat; k++) push_ev(g, c + k, 0, !ewe, ewe, ea, ed);
          push_ev(g, c, 2, 1'b0, ewe, ea, ed);
          if (!ewe) push_ev(g, c + lat, 3, 1'b1, 1'b0, ea, mem_fn(ea));
          free_at = c + lat;
          starve = 0;
          ext_gnt_at = c;
        end else if (core_pend) begin
          we = (core_kind != 0);
          for (int k = 0; k < lat; k++) push_ev(g, c + k, 0, !we, we, ca, cd);
          push_ev(g, c + lat - 1, 1, !we, we, ca, mem_fn(ca));
          core_granted = 1;
          core_done_at = c + lat - 1;
          free_at = c + lat;
          starve = ext_pend ? ((starve + 1 > limit) ? limit : starve + 1) : 0;
        end
      end
      if (!ext_pend) starve = 0;
      if (i >= ncyc && !core_pend && !ext_pend && c >= free_at) break;
    end
  endtask

  always @(negedge clock) begin
    if (mon_en && !reset) begin
      for (int g = 0; g < NInst; g++) begin
        bit [3:0] obs;
        obs[0] = mem_read[g] | mem_write[g];
        obs[1] = (core_read[g] | core_write[g]) & ~core_stall[g];
        obs[2] = ext_gnt[g];
        obs[3] = ext_rvalid[g];
        for (int i = sb.size() - 1; i >= 0; i--) begin
          if (sb[i].g == g && sb[i].cyc == cyc) begin
            checks++;
            case (sb[i].kind)
              0: if (!obs[0] || mem_read[g] !== sb[i].re || mem_write[g] !== sb[i].we ||
                     mem_addr[g] !== sb[i].addr ||
                     (sb[i].we && mem_write_data[g] !== sb[i].data)) begin
                errors++;
                $display("FAIL mem_cmd[%0d] cyc=%0d got rd=%0b wr=%0b a=%h d=%h want rd=%0b wr=%0b a=%h d=%h",
                         g, cyc, mem_read[g], mem_write[g], mem_addr[g], mem_write_data[g],
                         sb[i].re, sb[i].we, sb[i].addr, sb[i].data);
              end
              1: if (!obs[1] || (sb[i].re && core_read_data[g] !== sb[i].data)) begin
                errors++;
                $display("FAIL core_done[%0d] cyc=%0d got done=%0b rdata=%h want done=1 rdata=%h",
                         g, cyc, obs[1], core_read_data[g], sb[i].data);
              end
              2: if (!obs[2]) begin
                errors++;
                $display("FAIL ext_gnt[%0d] cyc=%0d got=0 want=1", g, cyc);
              end
              default: if (!obs[3] || ext_rdata[g] !== sb[i].data) begin
                errors++;
                $display("FAIL ext_rvalid[%0d] cyc=%0d got v=%0b d=%h want v=1 d=%h",
                         g, cyc, obs[3], ext_rdata[g], sb[i].data);
              end
            endcase
            obs[sb[i].kind] = 1'b0;
            sb.delete(i);
          end
        end
        for (int k = 0; k < 4; k++) begin
          if (obs[k]) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event[%0d] cyc=%0d kind=%0d got=1 want=0", g, cyc, k);
          end
        end
      end
    end
  end

  task automatic drain_and_check();
    repeat (5) @(posedge clock);
    mon_en = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
    end
    sb.delete();
  endtask

  initial begin
    // Requests asserted during reset must not reach memory.
    for (int g = 0; g < NInst; g++) begin
      core_read[g] = 1'b1; core_write[g] = 1'b0; core_addr[g] = 32'h10;
      core_write_data[g] = '0; ext_req[g] = 1'b1; ext_we[g] = 1'b0;
      ext_addr[g] = 32'h40; ext_wdata[g] = '0;
    end
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    for (int g = 0; g < NInst; g++) begin
      check("rst_mem_read", g, 32'(mem_read[g]), 32'd0);
      check("rst_mem_write", g, 32'(mem_write[g]), 32'd0);
      check("rst_ext_gnt", g, 32'(ext_gnt[g]), 32'd0);
      check("rst_core_stall", g, 32'(core_stall[g]), 32'd0);
      check("rst_ext_rvalid", g, 32'(ext_rvalid[g]), 32'd0);
      check("rst_ext_rdata", g, ext_rdata[g], 32'd0);
    end
    @(posedge clock);
    #1;
    for (int g = 0; g < NInst; g++) begin
      core_read[g] = 1'b0; ext_req[g] = 1'b0;
    end
    reset = 1'b0;

    mon_en = 1'b1;
    fork
      drive(0, 1500, 200);
      drive(1, 1500, 200);
      drive(2, 1500, 200);
    join
    drain_and_check();

    // External read interrupted by reset in its second cycle.
    @(posedge clock);
    #1;
    for (int g = 0; g < NInst; g++) begin
      ext_req[g] = 1'b1; ext_we[g] = 1'b0; ext_addr[g] = 32'h40;
    end
    @(negedge clock);
    for (int g = 0; g < NInst; g++) begin
      check("ri_ext_gnt", g, 32'(ext_gnt[g]), 32'd1);
      check("ri_mem_addr", g, mem_addr[g], 32'h40);
    end
    @(posedge clock);
    #1;
    for (int g = 0; g < NInst; g++) ext_req[g] = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    for (int g = 0; g < NInst; g++) begin
      check("ri_mem_read", g, 32'(mem_read[g]), 32'd0);
      check("ri_ext_rvalid", g, 32'(ext_rvalid[g]), 32'd0);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (4) begin
      @(negedge clock);
      for (int g = 0; g < NInst; g++) begin
        check("post_rst_rvalid", g, 32'(ext_rvalid[g]), 32'd0);
        check("post_rst_rdata", g, ext_rdata[g], 32'd0);
      end
    end

    mon_en = 1'b1;
    fork
      drive(0, 500, 0);
      drive(1, 500, 0);
      drive(2, 500, 0);
    join
    drain_and_check();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
